// File: rtl/dac_formatter.sv
// rtl/dac_formatter.sv - gain, round/saturate, soft-mute ramp and DAC word formatting
//
// Final Tx stage at the DAC sample clock. Three-stage pipeline:
//   S1 shift by gain_sh, round away DROP LSBs, clamp to OUT_W
//   S2 scale by the mute ramp level captured when the sample was accepted
//   S3 two's-complement / offset-binary formatting, saturation flag and counter
//
// Ports:
//   clk, rst       DAC sample clock, synchronous active-high reset
//   en             1 = unmute (ramp up / run), 0 = mute (ramp down / idle)
//   gain_sh        left shift 0..7 applied with each accepted sample
//   offset_bin     1 = offset-binary output, 0 = two's complement
//   sat_clr        clears sat_count (wins over a same-cycle increment)
//   in_valid       qualifies in_sample
//   in_sample      signed IN_W-bit input sample
//   out_valid      qualifies out_dac, 3 cycles after in_valid
//   out_dac        formatted DAC word
//   sat_flag       set on the out_valid beat whose sample was clamped
//   sat_count      saturated-sample count, sticks at all-ones
//   state          0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
module dac_formatter #(
  parameter int IN_W      = 20,
  parameter int OUT_W     = 14,
  parameter int RAMP_LOG2 = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       gain_sh,
  input  logic             offset_bin,
  input  logic             sat_clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sample,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_dac,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_count,
  output logic [1:0]       state
);

  localparam int DROP = IN_W - OUT_W;
  // One extra bit above IN_W+7 keeps the rounding add from overflowing.
  localparam int XW   = IN_W + 8;
  localparam int LW   = RAMP_LOG2 + 1;
  localparam int PW   = OUT_W + LW + 1;

  localparam logic signed [XW-1:0] RND  = XW'(1) << (DROP - 1);
  localparam logic signed [XW-1:0] RMAX = (XW'(1) << (OUT_W - 1)) - XW'(1);
  localparam logic signed [XW-1:0] RMIN = -(XW'(1) << (OUT_W - 1));
  localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LW-1:0]    LVL_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t          st;
  logic [LW-1:0]   level;
  logic [LW-1:0]   lvl_up;
  logic [LW-1:0]   lvl_dn;

  assign state = st;

  // ---------------- S1: gain, round, clamp ----------------
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] x_rnd;
  logic signed [XW-1:0] r_full;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [OUT_W-1:0]     r_sat;

  always_comb begin
    x_sh   = {{(XW-IN_W){in_sample[IN_W-1]}}, in_sample} <<< gain_sh;
    x_rnd  = x_sh + RND;
    r_full = x_rnd >>> DROP;
    sat_hi = r_full > RMAX;
    sat_lo = r_full < RMIN;
    r_sat  = sat_hi ? OMAX : (sat_lo ? OMIN : r_full[OUT_W-1:0]);
  end

  logic                    v1;
  logic signed [OUT_W-1:0] r1;
  logic                    s1;
  logic [LW-1:0]           l1;

  // ---------------- S2: ramp scaling ----------------
  logic signed [PW-1:0] r1_x;
  logic signed [PW-1:0] l1_x;
  logic signed [PW-1:0] prod;
  logic                 prod_unused;

  always_comb begin
    r1_x = {{(PW-OUT_W){r1[OUT_W-1]}}, r1};
    l1_x = {{(PW-LW){1'b0}}, l1};
    prod = r1_x * l1_x;
  end

  // Taking bits [RAMP_LOG2 +: OUT_W] is the arithmetic floor shift; the
  // product never exceeds |r| * 2^RAMP_LOG2, so the upper bits are sign only.
  assign prod_unused = ^{prod[PW-1:RAMP_LOG2+OUT_W], prod[RAMP_LOG2-1:0]};

  logic             v2;
  logic [OUT_W-1:0] y2;
  logic             s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      r1        <= '0;
      s1        <= 1'b0;
      l1        <= '0;
      v2        <= 1'b0;
      y2        <= '0;
      s2        <= 1'b0;
      out_valid <= 1'b0;
      out_dac   <= '0;
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        r1 <= r_sat;
        s1 <= sat_hi | sat_lo;
        l1 <= level;
      end

      v2 <= v1;
      if (v1) begin
        y2 <= prod[RAMP_LOG2 +: OUT_W];
        s2 <= s1;
      end

      // ---------------- S3: format, flag, count ----------------
      out_valid <= v2;
      sat_flag  <= v2 & s2;
      if (v2) begin
        out_dac <= offset_bin ? {~y2[OUT_W-1], y2[OUT_W-2:0]} : y2;
      end
      if (sat_clr) begin
        sat_count <= '0;
      end else if (v2 && s2 && sat_count != CNT_MAX) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

  // ---------------- mute ramp FSM ----------------
  // The level only moves on in_valid cycles and the accepted sample has
  // already captured the old level into l1. The guards stop a ramp that was
  // reversed before any sample arrived from stepping past 0 or full scale.
  assign lvl_up = (in_valid && level != LVL_FULL) ? level + 1'b1 : level;
  assign lvl_dn = (in_valid && level != '0)       ? level - 1'b1 : level;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      level <= '0;
    end else begin
      case (st)
        IDLE: begin
          level <= '0;
          if (en) st <= RAMP_UP;
        end
        RAMP_UP: begin
          level <= lvl_up;
          if (!en)                    st <= RAMP_DOWN;
          else if (lvl_up == LVL_FULL) st <= RUN;
        end
        RUN: begin
          level <= LVL_FULL;
          if (!en) st <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          level <= lvl_dn;
          if (en)                st <= RAMP_UP;
          else if (lvl_dn == '0) st <= IDLE;
        end
      endcase
    end
  end

endmodule
